// File: rtl/muldiv_ctrl_if.sv
// Bundle between the control unit, the muldiv sequencer and the mult/div datapath.
// The sequencer takes the slave view; the control unit / datapath side takes the master view.
interface muldiv_ctrl_if;
  logic        mult_req;
  logic        div_req;
  logic        abort;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic        mult_init;
  logic        mult_stop;
  logic        div_init;
  logic        div_stop;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport slave (
    input  mult_req, div_req, abort, op_a, op_b, hi_wr, lo_wr, wr_data,
    input  mult_hi, mult_lo, div_hi, div_lo,
    output opnd_a, opnd_b, mult_init, mult_stop, div_init, div_stop,
    output hi, lo, busy, done, div_zero
  );

  modport master (
    output mult_req, div_req, abort, op_a, op_b, hi_wr, lo_wr, wr_data,
    output mult_hi, mult_lo, div_hi, div_lo,
    input  opnd_a, opnd_b, mult_init, mult_stop, div_init, div_stop,
    input  hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: launches the shared mult or div unit, waits out its
// fixed latency, then commits the result into the architectural HI/LO pair.
module muldiv_ctrl #(
  parameter int MULT_LAT = 35,
  parameter int DIV_LAT  = 34
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_M_RUN = 2'd1;
  localparam logic [1:0] S_D_RUN = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [6:0] MULT_CNT = 7'(MULT_LAT);
  localparam logic [6:0] DIV_CNT  = 7'(DIV_LAT);

  logic [1:0]  state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic [31:0] opnd_a_q, opnd_a_d;
  logic [31:0] opnd_b_q, opnd_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        mult_init_q, mult_init_d;
  logic        mult_stop_q, mult_stop_d;
  logic        div_init_q, div_init_d;
  logic        div_stop_q, div_stop_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic        accept;

  // A divide by zero is not an accepted request, so mthi/mtlo still land that cycle.
  assign accept = bus.mult_req || (bus.div_req && (bus.op_b != 32'd0));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    opnd_a_d    = opnd_a_q;
    opnd_b_d    = opnd_b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mult_init_d = 1'b0;
    mult_stop_d = 1'b0;
    div_init_d  = 1'b0;
    div_stop_d  = 1'b0;
    done_d      = 1'b0;
    div_zero_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mult_req) begin
          opnd_a_d    = bus.op_a;
          opnd_b_d    = bus.op_b;
          cnt_d       = MULT_CNT;
          sel_d       = 1'b0;
          mult_init_d = 1'b1;
          state_d     = S_M_RUN;
        end else if (bus.div_req) begin
          if (bus.op_b != 32'd0) begin
            opnd_a_d   = bus.op_a;
            opnd_b_d   = bus.op_b;
            cnt_d      = DIV_CNT;
            sel_d      = 1'b1;
            div_init_d = 1'b1;
            state_d    = S_D_RUN;
          end else begin
            div_zero_d = 1'b1;
          end
        end
        if (!accept && bus.hi_wr) hi_d = bus.wr_data;
        if (!accept && bus.lo_wr) lo_d = bus.wr_data;
      end
      S_M_RUN, S_D_RUN: begin
        if (bus.abort) begin
          mult_stop_d = !sel_q;
          div_stop_d  = sel_q;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = S_WB;
        end
      end
      default: begin
        hi_d    = sel_q ? bus.div_hi : bus.mult_hi;
        lo_d    = sel_q ? bus.div_lo : bus.mult_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 7'd0;
      sel_q       <= 1'b0;
      opnd_a_q    <= 32'd0;
      opnd_b_q    <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      mult_init_q <= 1'b0;
      mult_stop_q <= 1'b0;
      div_init_q  <= 1'b0;
      div_stop_q  <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      opnd_a_q    <= opnd_a_d;
      opnd_b_q    <= opnd_b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mult_init_q <= mult_init_d;
      mult_stop_q <= mult_stop_d;
      div_init_q  <= div_init_d;
      div_stop_q  <= div_stop_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign bus.opnd_a    = opnd_a_q;
  assign bus.opnd_b    = opnd_b_q;
  assign bus.mult_init = mult_init_q;
  assign bus.mult_stop = mult_stop_q;
  assign bus.div_init  = div_init_q;
  assign bus.div_stop  = div_stop_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected pulses/HI-LO updates,
// a negedge monitor pops and compares; the mult/div units are modelled with exact latency.
module tb_muldiv_ctrl;
  localparam int MULT_LAT = 35;
  localparam int DIV_LAT  = 34;
  localparam int K_MINIT = 0, K_DINIT = 1, K_MSTOP = 2, K_DSTOP = 3, K_DONE = 4, K_DZ = 5;

  typedef struct {
    int          kind;
    longint      cyc;
    logic [31:0] d0;
    logic [31:0] d1;
  } ev_t;

  typedef struct {
    longint      cyc;
    bit          hen;
    bit          len;
    logic [31:0] h;
    logic [31:0] l;
  } upd_t;

  logic   clk = 1'b0;
  logic   rst;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     mon_en = 1'b0;

  ev_t    evq[$];
  upd_t   updq[$];
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;
  longint bs = 0;
  longint bu = 0;
  bit     act_mult = 1'b0;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] prod64(logic [31:0] a, logic [31:0] b);
    longint pa;
    longint pb;
    pa = $signed(a);
    pb = $signed(b);
    return pa * pb;
  endfunction

  function automatic logic [63:0] div64(logic [31:0] a, logic [31:0] b);
    int q;
    int r;
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  function automatic bit ref_busy(longint c);
    return (c >= bs) && (c < bu);
  endfunction

  function automatic string kname(int k);
    case (k)
      K_MINIT: return "mult_init";
      K_DINIT: return "div_init";
      K_MSTOP: return "mult_stop";
      K_DSTOP: return "div_stop";
      K_DONE:  return "done";
      default: return "div_zero";
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic pop_ev(int k, logic [31:0] a0, logic [31:0] a1);
    ev_t e;
    n_checks++;
    if (evq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s @cyc %0d: got pulse expected none", kname(k), cyc);
    end else begin
      e = evq.pop_front();
      if (e.kind != k || e.cyc != cyc || a0 !== e.d0 || a1 !== e.d1) begin
        n_fail++;
        $display("FAIL event: got %s @%0d (%h,%h) expected %s @%0d (%h,%h)",
                 kname(k), cyc, a0, a1, kname(e.kind), e.cyc, e.d0, e.d1);
      end
    end
  endtask

  task automatic push_ev(int k, longint c, logic [31:0] a0, logic [31:0] a1);
    ev_t e;
    e.kind = k; e.cyc = c; e.d0 = a0; e.d1 = a1;
    evq.push_back(e);
  endtask

  task automatic push_upd(longint c, bit he, bit le, logic [31:0] h, logic [31:0] l);
    upd_t u;
    u.cyc = c; u.hen = he; u.len = le; u.h = h; u.l = l;
    updq.push_back(u);
  endtask

  // Monitor: applies visible HI/LO changes, then compares levels and pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      while (updq.size() > 0 && updq[0].cyc <= cyc) begin
        if (updq[0].hen) ref_hi = updq[0].h;
        if (updq[0].len) ref_lo = updq[0].l;
        void'(updq.pop_front());
      end
      chk("busy", {31'd0, bus.busy}, {31'd0, ref_busy(cyc)});
      chk("hi", bus.hi, ref_hi);
      chk("lo", bus.lo, ref_lo);
      if (bus.mult_init) pop_ev(K_MINIT, bus.opnd_a, bus.opnd_b);
      if (bus.div_init)  pop_ev(K_DINIT, bus.opnd_a, bus.opnd_b);
      if (bus.mult_stop) pop_ev(K_MSTOP, 32'd0, 32'd0);
      if (bus.div_stop)  pop_ev(K_DSTOP, 32'd0, 32'd0);
      if (bus.done)      pop_ev(K_DONE, bus.hi, bus.lo);
      if (bus.div_zero)  pop_ev(K_DZ, 32'd0, 32'd0);
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed %s: got no pulse expected at cyc %0d", kname(evq[0].kind), evq[0].cyc);
        void'(evq.pop_front());
      end
    end
  end

  // Datapath stand-in: results are valid only in the single cycle LAT after init.
  longint m_ic = -1000;
  longint d_ic = -1000;
  logic [31:0] m_a, m_b, d_a, d_b;
  always @(negedge clk) begin
    logic [63:0] r;
    if (bus.mult_stop || rst) m_ic = -1000;
    if (bus.div_stop || rst)  d_ic = -1000;
    if (bus.mult_init) begin m_ic = cyc; m_a = bus.opnd_a; m_b = bus.opnd_b; end
    if (bus.div_init)  begin d_ic = cyc; d_a = bus.opnd_a; d_b = bus.opnd_b; end
    if (cyc == m_ic + MULT_LAT) begin
      r = prod64(m_a, m_b);
      bus.mult_hi = r[63:32];
      bus.mult_lo = r[31:0];
    end else begin
      bus.mult_hi = $urandom;
      bus.mult_lo = $urandom;
    end
    if (cyc == d_ic + DIV_LAT) begin
      r = div64(d_a, d_b);
      bus.div_hi = r[63:32];
      bus.div_lo = r[31:0];
    end else begin
      bus.div_hi = $urandom;
      bus.div_lo = $urandom;
    end
  end

  // One cycle of stimulus; the reference model decides the outcome from the rules.
  task automatic step(bit mr, bit dr, bit ab, logic [31:0] a, logic [31:0] b,
                      bit hw, bit lw, logic [31:0] wd, bit rs);
    longint n;
    bit busy_n, idle, acc;
    logic [63:0] r;
    ev_t  ekeep[$];
    upd_t ukeep[$];
    n = cyc;
    bus.mult_req = mr; bus.div_req = dr; bus.abort = ab;
    bus.op_a = a; bus.op_b = b;
    bus.hi_wr = hw; bus.lo_wr = lw; bus.wr_data = wd;
    rst = rs;
    busy_n = ref_busy(n);
    if (rs) begin
      foreach (evq[i]) if (evq[i].cyc <= n) ekeep.push_back(evq[i]);
      foreach (updq[i]) if (updq[i].cyc <= n) ukeep.push_back(updq[i]);
      evq = ekeep;
      updq = ukeep;
      push_upd(n + 1, 1'b1, 1'b1, 32'd0, 32'd0);
      if (busy_n) bu = n + 1;
    end else begin
      idle = !busy_n;
      acc = idle && (mr || (dr && b != 32'd0));
      if (idle && mr) begin
        r = prod64(a, b);
        push_ev(K_MINIT, n + 1, a, b);
        push_ev(K_DONE, n + MULT_LAT + 2, r[63:32], r[31:0]);
        push_upd(n + MULT_LAT + 2, 1'b1, 1'b1, r[63:32], r[31:0]);
        bs = n + 1; bu = n + MULT_LAT + 2; act_mult = 1'b1;
      end else if (idle && dr && b != 32'd0) begin
        r = div64(a, b);
        push_ev(K_DINIT, n + 1, a, b);
        push_ev(K_DONE, n + DIV_LAT + 2, r[63:32], r[31:0]);
        push_upd(n + DIV_LAT + 2, 1'b1, 1'b1, r[63:32], r[31:0]);
        bs = n + 1; bu = n + DIV_LAT + 2; act_mult = 1'b0;
      end else if (idle && dr) begin
        push_ev(K_DZ, n + 1, 32'd0, 32'd0);
      end
      if (idle && !acc && (hw || lw)) push_upd(n + 1, hw, lw, wd, wd);
      // Abort only bites before the write-back cycle.
      if (busy_n && ab && n != bu - 1) begin
        void'(evq.pop_back());
        void'(updq.pop_back());
        push_ev(act_mult ? K_MSTOP : K_DSTOP, n + 1, 32'd0, 32'd0);
        bu = n + 1;
      end
    end
    @(posedge clk);
    #2;
    bus.mult_req = 1'b0; bus.div_req = 1'b0; bus.abort = 1'b0;
    bus.hi_wr = 1'b0; bus.lo_wr = 1'b0; rst = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom; bus.wr_data = $urandom;
  endtask

  task automatic idle_step();
    step(0, 0, 0, $urandom, $urandom, 0, 0, $urandom, 0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (ref_busy(cyc) && guard < 200) begin
      idle_step();
      guard++;
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [31:0] ra, rb;
    rst = 1'b1;
    bus.mult_req = 0; bus.div_req = 0; bus.abort = 0;
    bus.op_a = 0; bus.op_b = 0; bus.hi_wr = 0; bus.lo_wr = 0; bus.wr_data = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_opnd_a", bus.opnd_a, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    step(1, 0, 0, 32'd7, 32'hFFFF_FFFD, 0, 0, 0, 0);
    chk("t1_mult_init", {31'd0, bus.mult_init}, 32'd1);
    wait_idle();
    chk("t1_done", {31'd0, bus.done}, 32'd1);
    chk("t1_hi", bus.hi, 32'hFFFF_FFFF);
    chk("t1_lo", bus.lo, 32'hFFFF_FFEB);

    step(0, 1, 0, 32'd100, 32'd7, 0, 0, 0, 0);
    chk("t2_div_init", {31'd0, bus.div_init}, 32'd1);
    wait_idle();
    chk("t2_lo", bus.lo, 32'd14);
    chk("t2_hi", bus.hi, 32'd2);
    step(1, 0, 0, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0);
    wait_idle();
    chk("t2_b2b_hi", bus.hi, 32'd1);
    chk("t2_b2b_lo", bus.lo, 32'd0);

    step(0, 0, 0, 0, 0, 1, 1, 32'h55, 0);
    step(0, 1, 0, 32'd9, 32'd0, 0, 0, 0, 0);
    chk("t3_div_zero", {31'd0, bus.div_zero}, 32'd1);
    chk("t3_busy", {31'd0, bus.busy}, 32'd0);
    idle_step();
    chk("t3_div_zero_drop", {31'd0, bus.div_zero}, 32'd0);
    chk("t3_hi", bus.hi, 32'h55);
    chk("t3_lo", bus.lo, 32'h55);

    step(1, 0, 0, $urandom, $urandom, 0, 0, 0, 0);
    repeat (25) idle_step();
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("t4_mult_stop", {31'd0, bus.mult_stop}, 32'd1);
    chk("t4_busy", {31'd0, bus.busy}, 32'd0);
    chk("t4_hi_kept", bus.hi, 32'h55);
    step(1, 0, 0, 32'd5, 32'd6, 0, 0, 0, 0);
    wait_idle();
    chk("t4_lo", bus.lo, 32'd30);

    step(1, 1, 0, 32'd9, 32'hFFFF_FFFC, 0, 0, 0, 0);
    repeat (10) idle_step();
    step(0, 0, 0, 0, 0, 1, 0, 32'hDEAD, 0);
    wait_idle();
    chk("t5_hi", bus.hi, 32'hFFFF_FFFF);
    chk("t5_lo", bus.lo, 32'hFFFF_FFDC);

    step(0, 1, 0, 32'd1234, 32'd11, 0, 0, 0, 0);
    repeat (15) idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t6_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_hi", bus.hi, 32'd0);
    chk("t6_opnd_a", bus.opnd_a, 32'd0);
    chk("t6_opnd_b", bus.opnd_b, 32'd0);
    repeat (45) idle_step();

    for (int i = 0; i < 2500; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      step($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 39) == 0, ra, rb,
           $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0, $urandom,
           $urandom_range(0, 499) == 0);
    end
    repeat (50) idle_step();
    chk("drain_evq", 32'(evq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of test expected finish before 1000000");
    $fatal(1, "timeout");
  end
endmodule
